nv_nvdla_pdp_rdma_eg_pipe_pn: RTL and testbench
===============================================

// Module: nv_nvdla_pdp_rdma_eg_pipe_pn
// PURPOSE
//  Parametrised valid/ready pipe stage for the PDP RDMA egress read-response path (mcif->pdp).
//  Circular buffer of DEPTH entries with WIDTH-bit payload. in_ready depends only on registered
//  occupancy, so there is no combinational path out_ready->in_ready. Full throughput at any DEPTH>=2.
//  Exports occupancy and almost-full so the RDMA request side can throttle outstanding reads.
// PARAMETERS
//  WIDTH     514        payload width (mcif2pdp rd rsp pd)
//  DEPTH     2          buffer entries; legal >=2; need not be a power of 2
//  AFULL_TH  DEPTH-1    pipe_afull asserts when pipe_cnt >= AFULL_TH; legal 1..DEPTH
//  CW        $clog2(DEPTH+1)  derived; width of pipe_cnt; not overridden
// PORTS
//  nvdla_core_clk  in   1      core clock; all state on rising edge
//  nvdla_core_rst  in   1      synchronous reset, active-high
//  in_valid        in   1      upstream valid (rd rsp valid d0)
//  in_ready        out  1      upstream ready (rd rsp ready d0)
//  in_pd           in   WIDTH  upstream payload
//  out_valid       out  1      downstream valid (rd rsp valid d1)
//  out_ready       in   1      downstream ready
//  out_pd          out  WIDTH  downstream payload
//  pipe_cnt        out  CW     current occupancy, 0..DEPTH
//  pipe_afull      out  1      pipe_cnt >= AFULL_TH
//  pipe_flush      in   1      present only with NVDLA_PDP_RDMA_PIPE_FLUSH_EN
// BEHAVIOUR
//  - State: mem[DEPTH] (no reset), wr_ptr, rd_ptr (0..DEPTH-1), cnt (CW bits).
//  - Reset (rst=1 at clk edge): wr_ptr=rd_ptr=cnt=0. While rst=1: in_ready=0, out_valid=0,
//    pipe_cnt=0, pipe_afull=0 (forced). First cycle after release: in_ready=1, out_valid=0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = !rst & (cnt < DEPTH). out_valid = !rst & (cnt != 0). out_pd = mem[rd_ptr].
//  - out_pd is don't-care while out_valid=0. While out_valid=1 and out_ready=0, out_pd holds.
//  - Latency: a beat pushed in cycle N is visible on out_* at cycle N+1 at the earliest.
//    There is no same-cycle fall-through, even when empty.
//  - push: mem[wr_ptr]<=in_pd. wr_ptr wraps DEPTH-1 -> 0 explicitly, not by bit overflow.
//  - pop: rd_ptr advances with the same wrap rule.
//  - cnt <= cnt + push - pop. Simultaneous push & pop leaves cnt unchanged, including at cnt=1.
//  - Full (cnt=DEPTH): in_ready=0. A pop this cycle frees an entry, and in_ready rises
//    next cycle (registered-ready rule).
//  - Empty (cnt=0): out_valid=0. A push this cycle yields out_valid=1 next cycle.
//  - Steady stream, out_ready=1: cnt settles at 1 with one beat per cycle.
//  - A stall fills to DEPTH. On release, back-to-back pops continue at one beat per cycle.
//  - Ordering is strictly FIFO. No beat is dropped or duplicated.
//  - Upstream must hold in_valid/in_pd stable until accepted. Bench asserts this; RTL does not check.
//  - Reset mid-operation: all buffered beats are discarded. No partial state survives.
//  - pipe_afull is combinational from registered cnt.
// CONFIGURATION
//  NVDLA_PDP_RDMA_PIPE_FLUSH_EN defined:
//  - pipe_flush port exists.
//  - pipe_flush=1 forces in_ready=0 that cycle.
//  - Next cycle: cnt=wr_ptr=rd_ptr=0, same as reset except mem is kept.
//  - out_valid/out_pd still present the head beat during the flush cycle. A pop there completes
//    a normal transfer; every other entry is discarded.
//  - Flush while rst=1: reset wins, with identical end state.
//  NVDLA_PDP_RDMA_PIPE_FLUSH_EN undefined: port absent; no flush logic.
// TESTING
//  T1 reset: rst=1 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, pipe_cnt=0;
//     cycle after release in_ready=1.
//  T2 stream: DEPTH=2, push 0x1..0x10 back-to-back, out_ready=1 -> 16 beats in order,
//     first at cycle+1, no bubbles, pipe_cnt stays 1.
//  T3 fill/stall: DEPTH=3, AFULL_TH=2, out_ready=0, push A,B,C,D -> A,B,C accepted.
//     pipe_afull=1 at cnt=2. cnt=3 gives in_ready=0. D is held.
//     Then out_ready=1 -> out A,B,C,D, and in_ready returns one cycle after the first pop.
//  T4 wrap: DEPTH=3, 10 random stall/push patterns crossing ptr 2->0 -> scoreboard exact match,
//     pipe_cnt matches the model each cycle.
//  T5 reset mid-op: cnt=2 with A,B buffered, pulse rst 1 cycle -> out_valid=0, cnt=0.
//     Push C -> next output is C, A/B never appear.
//  T6 (FLUSH_EN) flush at cnt=2, out_ready=1 -> head beat transfers, cnt=0 next cycle,
//     in_ready=0 during flush; a following push E outputs E.

Source files
------------

// File: rtl/nv_nvdla_pdp_rdma_eg_pipe_pn_if.sv
// ---------------------------------------------------------------------------
// nv_nvdla_pdp_rdma_eg_pipe_pn_if
//   Valid/ready bundle for the PDP RDMA egress read-response pipe.
//   Upstream side : in_valid / in_ready / in_pd
//   Downstream    : out_valid / out_ready / out_pd
//   master : the environment around the pipe. It drives the upstream beat and
//            the downstream ready.
//   slave  : the pipe itself.
// ---------------------------------------------------------------------------
interface nv_nvdla_pdp_rdma_eg_pipe_pn_if #(
  parameter int WIDTH = 514
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_pd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pd;

  modport master (
    output in_valid, in_pd, out_ready,
    input  in_ready, out_valid, out_pd
  );

  modport slave (
    input  in_valid, in_pd, out_ready,
    output in_ready, out_valid, out_pd
  );
endinterface

// File: rtl/nv_nvdla_pdp_rdma_eg_pipe_pn.sv
// ---------------------------------------------------------------------------
// nv_nvdla_pdp_rdma_eg_pipe_pn
//   Valid/ready pipe stage on the mcif->pdp read-response path. It is built
//   as a DEPTH-entry circular buffer. in_ready is derived only from the
//   registered occupancy, so there is no combinational out_ready->in_ready
//   path. The stage sustains one beat per cycle for any DEPTH >= 2. A beat
//   appears on the output one cycle after it is accepted, at the earliest.
//
// Ports
//   nvdla_core_clk_i  core clock, all state on rising edge
//   nvdla_core_rst_i  synchronous reset, active high
//   pipe              slave modport: in_valid/in_ready/in_pd, out_valid/out_ready/out_pd
//   pipe_cnt_o        occupancy 0..DEPTH (forced 0 during reset)
//   pipe_afull_o      pipe_cnt >= AFULL_TH (forced 0 during reset)
//   pipe_flush_i      only with NVDLA_PDP_RDMA_PIPE_FLUSH_EN. It discards the
//                     buffered beats and keeps the payload RAM contents.
//
// Optional feature macro: NVDLA_PDP_RDMA_PIPE_FLUSH_EN
// ---------------------------------------------------------------------------
module nv_nvdla_pdp_rdma_eg_pipe_pn #(
  parameter  int WIDTH    = 514,
  parameter  int DEPTH    = 2,
  parameter  int AFULL_TH = DEPTH - 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                                nvdla_core_clk_i,
  input  logic                                nvdla_core_rst_i,
  nv_nvdla_pdp_rdma_eg_pipe_pn_if.slave       pipe,
  output logic [CW-1:0]                       pipe_cnt_o,
  output logic                                pipe_afull_o
`ifdef NVDLA_PDP_RDMA_PIPE_FLUSH_EN
  ,
  input  logic                                pipe_flush_i
`endif
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  // payload storage, intentionally not reset
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q,    cnt_d;

  logic flush;
  logic in_rdy, out_vld;
  logic push, pop;

`ifdef NVDLA_PDP_RDMA_PIPE_FLUSH_EN
  assign flush = pipe_flush_i;
`else
  assign flush = 1'b0;
`endif

  // Ready/valid depend only on registered count plus the reset/flush inputs.
  // Ready does not look at out_ready, so a pop in a full cycle frees the
  // slot. Ready rises only in the next cycle.
  assign in_rdy  = !nvdla_core_rst_i && !flush && (cnt_q < DEPTH_C);
  assign out_vld = !nvdla_core_rst_i && (cnt_q != '0);

  assign push = pipe.in_valid && in_rdy;
  assign pop  = out_vld && pipe.out_ready;

  assign pipe.in_ready  = in_rdy;
  assign pipe.out_valid = out_vld;
  assign pipe.out_pd    = mem_q[rd_ptr_q];

  assign pipe_cnt_o   = nvdla_core_rst_i ? '0 : cnt_q;
  assign pipe_afull_o = !nvdla_core_rst_i && (cnt_q >= AFULL_C);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    // Wrap explicitly, because DEPTH need not be a power of two.
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    // A pop during the flush cycle still transfers the head beat.
    // Everything left behind is dropped.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge nvdla_core_clk_i) begin
    if (nvdla_core_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // push is already gated off by reset and flush through in_rdy
  always_ff @(posedge nvdla_core_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= pipe.in_pd;
  end

endmodule

// File: tb/tb_nv_nvdla_pdp_rdma_eg_pipe_pn.sv
// Two pipe instances: lane 0 uses DEPTH=2, AFULL_TH=1. Lane 1 uses DEPTH=3,
// AFULL_TH=2. Each lane has a scoreboard queue and a negedge monitor.
module tb_nv_nvdla_pdp_rdma_eg_pipe_pn;
  localparam int W = 514;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         iv      [2];
  logic [W-1:0] ipd     [2];
  logic         ordy    [2];
  logic         flush_s [2];
  logic         irdy    [2];
  logic         ovld    [2];
  logic [1:0]   cnt_w   [2];
  int           sbsz    [2];
  int           popcnt  [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int DEP = (g == 0) ? 2 : 3;
    localparam int TH  = (g == 0) ? 1 : 2;

    nv_nvdla_pdp_rdma_eg_pipe_pn_if #(.WIDTH(W)) bus ();
    logic [1:0] cnt;
    logic       afull;

    assign bus.in_valid  = iv[g];
    assign bus.in_pd     = ipd[g];
    assign bus.out_ready = ordy[g];
    assign irdy[g]  = bus.in_ready;
    assign ovld[g]  = bus.out_valid;
    assign cnt_w[g] = cnt;

    nv_nvdla_pdp_rdma_eg_pipe_pn #(.WIDTH(W), .DEPTH(DEP), .AFULL_TH(TH)) u_dut (
      .nvdla_core_clk_i (clk),
      .nvdla_core_rst_i (rst),
      .pipe             (bus.slave),
      .pipe_cnt_o       (cnt),
      .pipe_afull_o     (afull)
`ifdef NVDLA_PDP_RDMA_PIPE_FLUSH_EN
      ,
      .pipe_flush_i     (flush_s[g])
`endif
    );

    logic [W-1:0] sb [$];

    // This reference model only tracks which beats are accepted and not yet
    // popped. Every interface output is derived from that occupancy.
    always @(negedge clk) begin
      logic fl;
      logic [W-1:0] e;
`ifdef NVDLA_PDP_RDMA_PIPE_FLUSH_EN
      fl = flush_s[g];
`else
      fl = 1'b0;
`endif
      chk($sformatf("l%0d_in_ready", g), W'(bus.in_ready),
          W'(!rst && !fl && (sb.size() < DEP)));
      chk($sformatf("l%0d_out_valid", g), W'(bus.out_valid), W'(!rst && (sb.size() != 0)));
      chk($sformatf("l%0d_pipe_cnt", g), W'(cnt), rst ? W'(0) : W'(sb.size()));
      chk($sformatf("l%0d_pipe_afull", g), W'(afull), W'(!rst && (sb.size() >= TH)));
      if (bus.out_valid && ordy[g]) begin
        popcnt[g]++;
        if (sb.size() == 0) begin
          chk($sformatf("l%0d_unexpected_beat", g), bus.out_pd, '0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("l%0d_out_pd", g), bus.out_pd, e);
        end
      end
      if (iv[g] && bus.in_ready) sb.push_back(ipd[g]);
      if (rst || fl) sb.delete();
      sbsz[g] = sb.size();
    end

    // upstream protocol: a stalled beat must be held unchanged
    logic         stall_q = 1'b0;
    logic [W-1:0] hold_q  = '0;
    always @(posedge clk) begin
      if (stall_q && !(iv[g] && ipd[g] == hold_q)) begin
        errors++;
        $display("FAIL l%0d_hold_stable @%0t: got %0h expected %0h", g, $time, ipd[g], hold_q);
      end
      stall_q = iv[g] && !irdy[g];
      hold_q  = ipd[g];
    end
  end

  task automatic push(input int g, input logic [W-1:0] d);
    int n = 0;
    iv[g]  = 1'b1;
    ipd[g] = d;
    @(negedge clk);
    while (!irdy[g] && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk($sformatf("l%0d_push_timeout", g), W'(irdy[g]), W'(1));
    @(posedge clk);
    #1 iv[g] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] pat = 16'b1011_0010_0110_1100;

  initial begin
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ipd[i] = '0; ordy[i] = 1'b1; flush_s[i] = 1'b0; popcnt[i] = 0; sbsz[i] = 0;
    end
    // T1: reset held 3 cycles with a beat offered
    iv[1] = 1'b1; ipd[1] = W'(32'hA0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t1_ready_after_release", W'(irdy[1]), W'(1));
    chk("t1_valid_after_release", W'(ovld[1]), W'(0));
    @(posedge clk);
    #1 iv[1] = 1'b0;
    idle(3);

    // T2: back-to-back stream through DEPTH=2
    for (int i = 1; i <= 16; i++) push(0, W'(i));
    idle(4);
    chk("t2_beats_out", W'(popcnt[0]), W'(16));

    // T3: fill with the output stalled, then release
    ordy[1] = 1'b0;
    fork
      begin
        push(1, W'(32'hA));
        push(1, W'(32'hB));
        push(1, W'(32'hC));
        push(1, W'(32'hD));
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t3_full_cnt", W'(cnt_w[1]), W'(3));
        chk("t3_full_ready", W'(irdy[1]), W'(0));
        @(posedge clk);
        #1 ordy[1] = 1'b1;
      end
    join
    idle(6);

    // T4: stall pattern so that the pointers wrap several times
    fork
      for (int i = 0; i < 10; i++) push(1, W'(32'h40 + i));
      begin
        for (int i = 0; i < 24; i++) begin
          @(posedge clk);
          #1 ordy[1] = pat[i % 16];
        end
        ordy[1] = 1'b1;
      end
    join
    idle(6);

    // T5: reset with two beats buffered
    ordy[1] = 1'b0;
    push(1, W'(32'h50));
    push(1, W'(32'h51));
    @(negedge clk);
    chk("t5_cnt_before_rst", W'(cnt_w[1]), W'(2));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; ordy[1] = 1'b1;
    push(1, W'(32'h52));
    idle(4);

`ifdef NVDLA_PDP_RDMA_PIPE_FLUSH_EN
    // T6: flush at cnt=2 while popping. The head beat goes out and the rest is dropped.
    ordy[1] = 1'b0;
    push(1, W'(32'hF0));
    push(1, W'(32'hF1));
    flush_s[1] = 1'b1; ordy[1] = 1'b1;
    @(negedge clk);
    chk("t6_ready_in_flush", W'(irdy[1]), W'(0));
    @(posedge clk);
    #1 flush_s[1] = 1'b0;
    @(negedge clk);
    chk("t6_cnt_after_flush", W'(cnt_w[1]), W'(0));
    @(posedge clk);
    #1;
    push(1, W'(32'hE));
    idle(4);
`endif

    chk("l0_drained", W'(sbsz[0]), W'(0));
    chk("l1_drained", W'(sbsz[1]), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog @%0t: got timeout expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
